// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and priority helpers for the interrupt controller.
package irq_pkg;

  localparam int N_IRQ = 4;
  localparam int ID_W  = $clog2(N_IRQ);

  localparam logic [15:0] VEC_BASE_DEF   = 16'h03C0;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'h0010;

  localparam logic [N_IRQ-1:0] LSB_ONE = N_IRQ'(1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // One-hot of the lowest set bit (index 0 is highest priority); zero in, zero out.
  function automatic logic [N_IRQ-1:0] lowest_set(input logic [N_IRQ-1:0] v);
    logic [N_IRQ-1:0] r;
    r = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = LSB_ONE << i;
    end
    return r;
  endfunction

  function automatic logic [ID_W-1:0] onehot_idx(input logic [N_IRQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one interrupt line.
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Prioritised, nesting-aware interrupt controller offering one request at a time
// to the core over a req/ack handshake, retired by end-of-interrupt.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] interrupt_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_in_i,
  output logic [N_IRQ-1:0] mask_out_o,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [15:0]      irq_vector_o,
  input  logic             irq_ack_i,
  input  logic             irq_eoi_i,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] in_service_o
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] above, eligible, win_oh, ack_oh, eoi_oh;
  logic [ID_W-1:0]  win_id;
  logic [15:0]      win_vector;
  logic             ack_fire;

  state_e           state_q;
  logic             irq_req_q;
  logic [ID_W-1:0]  irq_id_q;
  logic [15:0]      irq_vector_q;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
    irq_sync_edge u_sync_edge (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .irq_i  (interrupt_i[gi]),
      .rise_o (rise[gi])
    );
  end

  // Only indices strictly above the highest-priority in-service handler may preempt;
  // with nothing in service the subtraction wraps to all ones.
  assign above      = lowest_set(in_service_q) - LSB_ONE;
  assign eligible   = pending_q & mask_q & above;
  assign win_oh     = lowest_set(eligible);
  assign win_id     = onehot_idx(win_oh);
  assign win_vector = VEC_BASE + VEC_STRIDE * 16'(win_id);

  assign ack_fire = (state_q == REQ) && irq_ack_i;
  assign ack_oh   = ack_fire  ? (LSB_ONE << irq_id_q)     : '0;
  assign eoi_oh   = irq_eoi_i ? lowest_set(in_service_q) : '0;

  // A fresh edge on the line being acked re-arms it; EOI uses the pre-edge in-service set.
  assign pending_d    = (pending_q & ~ack_oh) | rise;
  assign in_service_d = (in_service_q & ~eoi_oh) | ack_oh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      if (mask_we_i) mask_q <= mask_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      irq_req_q    <= 1'b0;
      irq_id_q     <= '0;
      irq_vector_q <= VEC_BASE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q      <= REQ;
            irq_req_q    <= 1'b1;
            irq_id_q     <= win_id;
            irq_vector_q <= win_vector;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mask_out_o   = mask_q;
  assign irq_req_o    = irq_req_q;
  assign irq_id_o     = irq_id_q;
  assign irq_vector_o = irq_vector_q;
  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues expected offers, a monitor
// compares each new offer and checks it holds steady until ack.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  interrupt = 4'b0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_in = 4'b0;
  logic        irq_ack = 1'b0;
  logic        irq_eoi = 1'b0;
  logic [3:0]  mask_out;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [15:0] irq_vector;
  logic [3:0]  pending;
  logic [3:0]  in_service;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [17:0] exp_q[$];
  logic [17:0] cur_exp = '0;
  logic        prev_req = 1'b0;

  irq_controller dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .interrupt_i  (interrupt),
    .mask_we_i    (mask_we),
    .mask_in_i    (mask_in),
    .mask_out_o   (mask_out),
    .irq_req_o    (irq_req),
    .irq_id_o     (irq_id),
    .irq_vector_o (irq_vector),
    .irq_ack_i    (irq_ack),
    .irq_eoi_i    (irq_eoi),
    .pending_o    (pending),
    .in_service_o (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: a rising IRQ_REQ is an offer; compare it, then require it to hold.
  always @(negedge clk) begin
    if (irq_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_offer: got id %0d vec %h expected no offer", irq_id, irq_vector);
      end else begin
        cur_exp = exp_q.pop_front();
        $display("offer id=%0d vector=%h", irq_id, irq_vector);
        check("offer_id", 16'(irq_id), 16'(cur_exp[17:16]));
        check("offer_vec", irq_vector, cur_exp[15:0]);
      end
    end else if (irq_req && prev_req) begin
      check("hold_id", 16'(irq_id), 16'(cur_exp[17:16]));
      check("hold_vec", irq_vector, cur_exp[15:0]);
    end
    prev_req = irq_req;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] lines);
    interrupt = lines;
    step(2);
    interrupt = 4'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!irq_req && n < 20) begin
      step();
      n++;
    end
    check(name, 16'(irq_req), 16'd1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    step();
    irq_eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_in = m;
    mask_we = 1'b1;
    step();
    mask_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    check("rst_req", 16'(irq_req), 16'd0);
    check("rst_id", 16'(irq_id), 16'd0);
    check("rst_vec", irq_vector, 16'h03C0);
    check("rst_mask", 16'(mask_out), 16'h000F);
    check("rst_pend", 16'(pending), 16'd0);
    check("rst_insvc", 16'(in_service), 16'd0);
    rst_n = 1'b1;
    step(2);

    // Ack while idle is ignored
    do_ack();
    check("idle_ack_insvc", 16'(in_service), 16'd0);
    check("idle_ack_req", 16'(irq_req), 16'd0);

    // Single request and latency
    exp_q.push_back({2'd2, 16'h03E0});
    interrupt = 4'b0100;
    step();
    step();
    interrupt = 4'b0;
    check("t1_pend_k1", 16'(pending), 16'd0);
    step();
    check("t1_pend_k2", 16'(pending), 16'h0004);
    check("t1_req_k2", 16'(irq_req), 16'd0);
    step();
    check("t1_req_k3", 16'(irq_req), 16'd1);
    do_ack();
    check("t1_pend_ack", 16'(pending), 16'd0);
    check("t1_insvc_ack", 16'(in_service), 16'h0004);
    check("t1_req_after_ack", 16'(irq_req), 16'd0);
    do_eoi();
    check("t1_insvc_eoi", 16'(in_service), 16'd0);

    // Priority between lines 3 and 1
    exp_q.push_back({2'd1, 16'h03D0});
    exp_q.push_back({2'd3, 16'h03F0});
    pulse(4'b1010);
    wait_req("t2_offer1");
    do_ack();
    check("t2_insvc", 16'(in_service), 16'h0002);
    check("t2_pend", 16'(pending), 16'h0008);
    check("t2_req_gap", 16'(irq_req), 16'd0);
    do_eoi();
    check("t2_eoi_gap", 16'(irq_req), 16'd0);
    step();
    check("t2_eoi_lat", 16'(irq_req), 16'd1);
    do_ack();
    do_eoi();
    check("t2_insvc_end", 16'(in_service), 16'd0);

    // Nesting
    exp_q.push_back({2'd2, 16'h03E0});
    pulse(4'b0100);
    wait_req("t3_offer2");
    do_ack();
    check("t3_insvc2", 16'(in_service), 16'h0004);
    pulse(4'b1000);
    step(4);
    check("t3_pend3", 16'(pending), 16'h0008);
    check("t3_blocked", 16'(irq_req), 16'd0);
    exp_q.push_back({2'd0, 16'h03C0});
    pulse(4'b0001);
    wait_req("t3_offer0");
    do_ack();
    check("t3_insvc02", 16'(in_service), 16'h0005);
    check("t3_pend_held", 16'(pending), 16'h0008);
    do_eoi();
    check("t3_eoi1", 16'(in_service), 16'h0004);
    step(2);
    check("t3_still_blocked", 16'(irq_req), 16'd0);
    exp_q.push_back({2'd3, 16'h03F0});
    do_eoi();
    check("t3_eoi2", 16'(in_service), 16'd0);
    wait_req("t3_offer3");
    do_ack();
    do_eoi();

    // Mask gates eligibility without clearing pending
    write_mask(4'b1110);
    check("t4_mask", 16'(mask_out), 16'h000E);
    pulse(4'b0001);
    step(4);
    check("t4_pend", 16'(pending), 16'h0001);
    check("t4_noreq", 16'(irq_req), 16'd0);
    exp_q.push_back({2'd0, 16'h03C0});
    write_mask(4'hF);
    check("t4_mask_gap", 16'(irq_req), 16'd0);
    step();
    check("t4_mask_lat", 16'(irq_req), 16'd1);
    do_ack();
    do_eoi();

    // Stability during REQ and coalescing
    exp_q.push_back({2'd2, 16'h03E0});
    pulse(4'b0100);
    wait_req("t5_offer2");
    pulse(4'b0101);
    step(4);
    check("t5_id_stable", 16'(irq_id), 16'd2);
    check("t5_req_stable", 16'(irq_req), 16'd1);
    check("t5_pend", 16'(pending), 16'h0005);
    exp_q.push_back({2'd0, 16'h03C0});
    do_ack();
    check("t5_pend_ack", 16'(pending), 16'h0001);
    check("t5_insvc_ack", 16'(in_service), 16'h0004);
    wait_req("t5_offer0");
    do_ack();
    check("t5_insvc02", 16'(in_service), 16'h0005);
    do_eoi();
    do_eoi();
    check("t5_insvc_end", 16'(in_service), 16'd0);

    // ACK and EOI in the same cycle
    exp_q.push_back({2'd3, 16'h03F0});
    pulse(4'b1000);
    wait_req("t6_offer3");
    do_ack();
    check("t6_insvc3", 16'(in_service), 16'h0008);
    exp_q.push_back({2'd1, 16'h03D0});
    pulse(4'b0010);
    wait_req("t6_offer1");
    irq_ack = 1'b1;
    irq_eoi = 1'b1;
    step();
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    check("t6_ack_eoi", 16'(in_service), 16'h0002);
    do_eoi();
    check("t6_insvc_end", 16'(in_service), 16'd0);

    // Asynchronous reset while offering
    write_mask(4'b0111);
    check("t7_mask", 16'(mask_out), 16'h0007);
    exp_q.push_back({2'd2, 16'h03E0});
    pulse(4'b0100);
    wait_req("t7_offer2");
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_req", 16'(irq_req), 16'd0);
    check("t7_rst_id", 16'(irq_id), 16'd0);
    check("t7_rst_vec", irq_vector, 16'h03C0);
    check("t7_rst_mask", 16'(mask_out), 16'h000F);
    check("t7_rst_pend", 16'(pending), 16'd0);
    check("t7_rst_insvc", 16'(in_service), 16'd0);
    step();
    rst_n = 1'b1;
    step(4);
    check("t7_idle_after_rst", 16'(irq_req), 16'd0);

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sits between the four external `INTERRUPT` lines and the pipelined core's fetch stage. It synchronizes and edge-detects the raw lines, latches pending requests, applies a software mask and fixed priority, and issues one request at a time with a handler vector. The core accepts a request with a req/ack handshake and retires it with end-of-interrupt. The block tracks nesting so that only strictly higher-priority interrupts can preempt a running handler.

## Interface
- `N_IRQ`, 4: number of interrupt lines. Index 0 has the highest priority.
- `VEC_BASE`, 16'h03C0: handler address for IRQ 0.
- `VEC_STRIDE`, 16'h0010: address spacing between handler vectors.
- `CLK` input, 1: single clock. All state changes on the rising edge.
- `RST` input, 1: asynchronous, active-low reset.
- `INTERRUPT` input, N_IRQ: raw request lines. Asynchronous to CLK, active-high, rising-edge triggered.
- `MASK_WE` input, 1: write strobe for the mask register.
- `MASK_IN` input, N_IRQ: new mask value. A 1 enables that line.
- `MASK_OUT` output, N_IRQ: current mask.
- `IRQ_REQ` output, 1: a request is being offered to the core.
- `IRQ_ID` output, 2: index of the offered request.
- `IRQ_VECTOR` output, 16: `VEC_BASE + IRQ_ID*VEC_STRIDE`.
- `IRQ_ACK` input, 1: the core has taken the offered request (fetch redirected).
- `IRQ_EOI` input, 1: the core has retired a return-from-interrupt.
- `PENDING` output, N_IRQ: latched, not-yet-acknowledged requests.
- `IN_SERVICE` output, N_IRQ: requests acknowledged but not yet EOI'd.

## Operation
**Per-line front end**
- Two-flop synchronizer, then a registered previous value.
- `edge[i] = sync2[i] & ~prev[i]`.

**Pending register**
- Set on `edge[i]`. Cleared when the request is acknowledged with `IRQ_ID == i`.
- If an edge and the ack of the same line occur in the same cycle, pending stays 1; the new edge wins.
- An edge on a line that is already pending coalesces into the existing request; no count is kept.

**Mask**
- `MASK_WE` loads `MASK_IN` on the next edge.
- Masking never clears pending; it only gates eligibility.

**Eligibility**
- `eligible = PENDING & MASK & above`, where `above` has bits set only at indices strictly lower than the lowest set bit of `IN_SERVICE`.
- When `IN_SERVICE` is 0, `above` is all ones.
- The winner is the lowest eligible index.

**FSM**
- States: IDLE, REQ.
- IDLE → REQ when eligible is non-zero; `IRQ_ID` and `IRQ_VECTOR` are registered from the winner.
- REQ → IDLE on `IRQ_ACK`. On that edge: clear `PENDING[IRQ_ID]`, set `IN_SERVICE[IRQ_ID]`.

**Handshake rules**
- While in REQ, `IRQ_REQ`, `IRQ_ID` and `IRQ_VECTOR` hold stable until ack. A newly arriving higher-priority line does not replace the offer, and a mask change during REQ does not retract it.
- `IRQ_ACK` outside REQ is ignored.

**End of interrupt**
- `IRQ_EOI` clears the lowest set bit of `IN_SERVICE`.
- EOI with `IN_SERVICE == 0` is ignored.
- If ACK and EOI occur in the same cycle, EOI acts on the pre-edge `IN_SERVICE`, then the ack bit is set.

## Timing
**Reset**
- All of the following reset to 0: sync flops, `prev`, `PENDING`, `IN_SERVICE`, `IRQ_REQ`, `IRQ_ID`.
- `MASK_OUT` resets to all ones. `IRQ_VECTOR` resets to `VEC_BASE`. FSM resets to IDLE.
- Reset mid-REQ drops the offer immediately (asynchronously).
- A line held high across reset release is seen as one rising edge.

**Latency**
- Take the edge at which `INTERRUPT[i]` is first sampled high as edge k.
- `sync2` high after k+1, `PENDING[i]` set after k+2, `IRQ_REQ` high after k+3.

**Back-to-back and retirement**
- After an ack, `IRQ_REQ` is low for at least one cycle; the next offer appears at the earliest on the second edge after the ack.
- An EOI unblocks lower-priority pending requests, which are offered 1 cycle later (IDLE → REQ on the next edge).

## Structure
- Package `irq_pkg` holds:
  - `N_IRQ`, the `IRQ_ID` width, `VEC_BASE` and `VEC_STRIDE` defaults;
  - the state enum `{IDLE, REQ}`;
  - a `lowest_set` priority function shared by winner selection and EOI.
- Sub-module `irq_sync_edge`: 2-flop synchronizer plus edge detector for one line, instantiated N_IRQ times.

## Test plan
- **Single request:** reset, release, pulse `INTERRUPT=4'b0100` for 2 cycles → `IRQ_REQ` high 3 cycles after sampling, `IRQ_ID=2`, `IRQ_VECTOR=16'h03E0`. Ack → `PENDING=0`, `IN_SERVICE=4'b0100`.
- **Priority:** raise lines 3 and 1 in the same cycle → first offer `IRQ_ID=1`. Ack and EOI it → next offer `IRQ_ID=3`.
- **Nesting:** with line 2 in service, raise 3 then 0 → 0 is offered and 3 is held pending. EOI twice (clears 0, then 2) → 3 offered.
- **Mask:** `MASK_IN=4'b1110`, raise line 0 → `PENDING=4'b0001`, no `IRQ_REQ`. Write mask `4'hF` → `IRQ_REQ` 1 cycle later with `IRQ_ID=0`.
- **Stability and coalescing:** in REQ for line 2, raise line 0 and re-pulse line 2 → `IRQ_ID` stays 2 until ack. After ack, `PENDING=4'b0001` and the line-2 re-pulse coalesced.
- **Edge cases:** ACK+EOI same cycle with `IN_SERVICE=4'b1000` and offer `ID=1` → `IN_SERVICE=4'b0010`. Assert `RST` low during REQ → all outputs return to reset values immediately.
